xor_parity_acc: RTL and testbench
=================================

XOR_PARITY_ACC -- requirements
Module: xor_parity_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input word width in bits (>=1).
REQ-002 SHALL have parameter CNT_W, default 8: word-counter width in bits (>=1).
REQ-003 SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have one clock and an asynchronous active-low reset; no other clocks or resets.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: in_data/in_last valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-009 SHALL have port in_data, input, WIDTH: frame word.
REQ-010 SHALL have port in_last, input, 1: word is last of frame.
REQ-011 SHALL have port out_valid, output, 1: frame result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port out_parity, output, 1: frame parity bit.
REQ-014 SHALL have port out_colpar, output, WIDTH: column-wise XOR of all frame words.
REQ-015 SHALL have port out_count, output, CNT_W: words in frame, saturating.
REQ-016 SHALL have port out_ovf, output, 1: frame word count exceeded 2^CNT_W-1.

Function
REQ-017 SHALL implement states IDLE (no word of the current frame accepted), ACCUM (>=1 word accepted, no last yet) and HOLD (result pending).
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD; in_ready SHALL depend on state only.
REQ-019 SHALL accept a word only on a rising edge with in_valid=1 and in_ready=1; in_valid in HOLD SHALL be ignored.
REQ-020 SHALL, on each accepted word, update colpar_acc ^= in_data.
REQ-021 SHALL, on each accepted word, increment cnt_acc, saturating at 2^CNT_W-1.
REQ-022 SHALL set a sticky ovf_acc when an accepted word arrives with cnt_acc already at 2^CNT_W-1.
REQ-023 SHALL, on an accepted non-last word, enter or stay in ACCUM.
REQ-024 SHALL, on an accepted word with in_last=1, on that same edge load the outputs with the final values including that word, set out_valid=1, clear the accumulators and enter HOLD.
REQ-025 SHALL set out_colpar to the final colpar_acc.
REQ-026 SHALL set out_parity to XOR-reduce(out_colpar) XOR ODD.
REQ-027 SHALL set out_count to the final cnt_acc.
REQ-028 SHALL set out_ovf to the final ovf_acc.
REQ-029 SHALL give a latency of one edge: out_valid is high in the cycle after the edge accepting the last word.
REQ-030 SHALL handle single-word frames (in_last on the first word) as IDLE to HOLD directly.
REQ-031 SHALL hold out_valid, out_parity, out_colpar, out_count and out_ovf stable in HOLD until out_valid=1 and out_ready=1 on an edge.
REQ-032 SHALL, on that handshake edge, clear out_valid to 0 and enter IDLE; in_ready SHALL return to 1 in the following cycle.
REQ-033 SHALL keep out_* data values unchanged after the handshake until the next frame result loads.
REQ-034 SHALL allow out_ready to be asserted before out_valid; it has no effect outside HOLD.
REQ-035 SHALL not accept input on the handshake edge (no same-cycle input/output overlap).

Reset
REQ-036 SHALL, with rst_n=0, immediately (asynchronously) force state IDLE, out_valid=0, out_parity=0, out_colpar=0, out_count=0 and out_ovf=0.
REQ-037 SHALL, with rst_n=0, immediately clear all accumulators; in_ready SHALL be 1 while in IDLE.
REQ-038 SHALL, on reset during ACCUM or HOLD, discard the partial frame and any pending result; the first word after release starts a new frame.

Verification
REQ-039 SHALL pass: WIDTH=8, ODD=0, single word 0x00 with in_last -> next cycle out_valid=1, out_parity=0, out_colpar=0x00, out_count=1, out_ovf=0.
REQ-040 SHALL pass: words 0x01, 0x03, 0x07 (last on 0x07) -> out_colpar=0x05, out_parity=0, out_count=3.
REQ-041 SHALL pass: result pending with out_ready=0 for 4 cycles while in_valid=1, in_data=0xAA -> outputs stable, in_ready=0, no word accepted; out_ready=1 -> out_valid=0 next cycle and in_ready=1.
REQ-042 SHALL pass: ODD=1, single word 0x00 -> out_parity=1; single word 0x01 -> out_parity=0.
REQ-043 SHALL pass: CNT_W=2, five words of 0x01 (last on the fifth) -> out_count=3, out_ovf=1, out_colpar=0x01, out_parity=1.
REQ-044 SHALL pass: reset pulsed after two accepted words 0x0F, 0xF0 -> all outputs 0 during reset; then single word 0xFF with in_last -> out_colpar=0xFF, out_parity=0, out_count=1.

Source files
------------

// File: rtl/xor_parity_acc.sv
// xor_parity_acc: accumulates a column-wise XOR, a saturating word count and
// an overflow flag over a frame of words, then presents one registered result
// that is held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Input words are accepted only in IDLE/ACCUM. In HOLD the result is
// held until out_ready is seen with out_valid. No input is accepted on the
// edge that hands the result over.
module xor_parity_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [WIDTH-1:0] out_colpar,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             ODD_BIT = (ODD != 0);

    state_t           state;
    logic [WIDTH-1:0] colpar_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic             ovf_acc;

    logic             accept;
    logic             cnt_full;
    logic [WIDTH-1:0] colpar_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // Ready depends on state only, so it never combinationally follows in_valid.
    assign in_ready  = (state != HOLD);
    assign dbg_state = state;

    // Values the accumulators take if the word on the bus is accepted.
    always_comb begin
        accept      = in_valid && in_ready;
        cnt_full    = (cnt_acc == CNT_MAX);
        colpar_next = colpar_acc ^ in_data;
        cnt_next    = cnt_full ? cnt_acc : (cnt_acc + CNT_ONE);
        ovf_next    = ovf_acc | cnt_full;
    end

    // Frame FSM, accumulators and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            colpar_acc <= '0;
            cnt_acc    <= '0;
            ovf_acc    <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_colpar <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            // Result includes the last word; accumulators
                            // restart so the next frame begins clean.
                            out_colpar <= colpar_next;
                            out_parity <= (^colpar_next) ^ ODD_BIT;
                            out_count  <= cnt_next;
                            out_ovf    <= ovf_next;
                            out_valid  <= 1'b1;
                            colpar_acc <= '0;
                            cnt_acc    <= '0;
                            ovf_acc    <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            colpar_acc <= colpar_next;
                            cnt_acc    <= cnt_next;
                            ovf_acc    <= ovf_next;
                            state      <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Data outputs keep their values after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_parity_acc.sv
// Bench for xor_parity_acc: three instances share one input stream
// (default, odd parity, 2-bit counter) and each is checked against its own
// expected-result queue filled by a reference model as frames are driven.
module tb_xor_parity_acc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       u0_in_ready, u1_in_ready, u2_in_ready;
    logic       u0_out_valid, u1_out_valid, u2_out_valid;
    logic       u0_parity, u1_parity, u2_parity;
    logic [7:0] u0_colpar, u1_colpar, u2_colpar;
    logic [7:0] u0_count, u1_count;
    logic [1:0] u2_count;
    logic       u0_ovf, u1_ovf, u2_ovf;
    logic [1:0] u0_state, u1_state, u2_state;

    int checks   = 0;
    int failures = 0;

    // Packed result: {ovf, count[7:0], parity, colpar[7:0]}
    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    logic [17:0] exp_q2[$];
    logic [7:0]  frame_q[$];

    logic [17:0] obs0, obs1, obs2;
    assign obs0 = {u0_ovf, u0_count, u0_parity, u0_colpar};
    assign obs1 = {u1_ovf, u1_count, u1_parity, u1_colpar};
    assign obs2 = {u2_ovf, 6'd0, u2_count, u2_parity, u2_colpar};

    xor_parity_acc #(.WIDTH(8), .CNT_W(8), .ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u0_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u0_out_valid),
        .out_ready(out_ready), .out_parity(u0_parity), .out_colpar(u0_colpar),
        .out_count(u0_count), .out_ovf(u0_ovf), .dbg_state(u0_state)
    );

    xor_parity_acc #(.WIDTH(8), .CNT_W(8), .ODD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u1_out_valid),
        .out_ready(out_ready), .out_parity(u1_parity), .out_colpar(u1_colpar),
        .out_count(u1_count), .out_ovf(u1_ovf), .dbg_state(u1_state)
    );

    xor_parity_acc #(.WIDTH(8), .CNT_W(2), .ODD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u2_out_valid),
        .out_ready(out_ready), .out_parity(u2_parity), .out_colpar(u2_colpar),
        .out_count(u2_count), .out_ovf(u2_ovf), .dbg_state(u2_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model(input int n, input logic [7:0] colpar,
                                          input int cnt_max, input logic odd);
        int   c;
        logic ovf;
        c   = (n > cnt_max) ? cnt_max : n;
        ovf = (n > cnt_max);
        return {ovf, 8'(c), (^colpar) ^ odd, colpar};
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_obs0"}, 32'(obs0), 32'd0);
        check({tag, "_obs1"}, 32'(obs1), 32'd0);
        check({tag, "_obs2"}, 32'(obs2), 32'd0);
        check({tag, "_valid"}, {29'd0, u0_out_valid, u1_out_valid, u2_out_valid}, 32'd0);
        check({tag, "_ready"}, {29'd0, u0_in_ready, u1_in_ready, u2_in_ready}, 32'd7);
        check({tag, "_state"}, {26'd0, u0_state, u1_state, u2_state}, 32'd0);
    endtask

    // Driver: present one word at negedge, let one rising edge take it.
    task automatic drive_word(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("in_ready_at_drive", {31'd0, u0_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drive every word of frame_q, push the model results, check latency.
    task automatic send_frame();
        logic [7:0] cp;
        int         n;
        cp = 8'h00;
        n  = frame_q.size();
        for (int i = 0; i < n; i++) begin
            cp = cp ^ frame_q[i];
            drive_word(frame_q[i], (i == n - 1));
        end
        exp_q0.push_back(model(n, cp, 255, 1'b0));
        exp_q1.push_back(model(n, cp, 255, 1'b1));
        exp_q2.push_back(model(n, cp, 3, 1'b0));
        check("latency_valid", {29'd0, u0_out_valid, u1_out_valid, u2_out_valid}, 32'd7);
        frame_q.delete();
    endtask

    // Scoreboard: hold for delay cycles (optionally with junk input), then
    // take the result and compare with the queued expectation.
    task automatic get_result(input int delay, input logic junk);
        logic [17:0] e0, e1, e2;
        int          budget;
        if (exp_q0.size() == 0 || exp_q1.size() == 0 || exp_q2.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
            return;
        end
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        e2 = exp_q2.pop_front();
        for (int i = 0; i < delay; i++) begin
            out_ready = 1'b0;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_in_ready", {29'd0, u0_in_ready, u1_in_ready, u2_in_ready}, 32'd0);
            check("hold_valid", {29'd0, u0_out_valid, u1_out_valid, u2_out_valid}, 32'd7);
            check("hold_obs0", 32'(obs0), 32'(e0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (!u0_out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("result_obs0", 32'(obs0), 32'(e0));
        check("result_obs1", 32'(obs1), 32'(e1));
        check("result_obs2", 32'(obs2), 32'(e2));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("after_hs_valid", {29'd0, u0_out_valid, u1_out_valid, u2_out_valid}, 32'd0);
        check("after_hs_ready", {29'd0, u0_in_ready, u1_in_ready, u2_in_ready}, 32'd7);
        check("after_hs_data0", 32'(obs0), 32'(e0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_state("reset_initial");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single zero word
        frame_q = '{8'h00};
        send_frame();
        get_result(0, 1'b0);

        // 01 ^ 03 ^ 07 = 05
        frame_q = '{8'h01, 8'h03, 8'h07};
        send_frame();
        get_result(0, 1'b0);

        // Result held 4 cycles while junk 0xAA is offered
        frame_q = '{8'h5A};
        send_frame();
        get_result(4, 1'b1);
        // If 0xAA had been taken the next frame would not read back 0x01
        frame_q = '{8'h01};
        send_frame();
        get_result(0, 1'b0);

        // Five 0x01 words: saturates and overflows the 2-bit counter
        frame_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_frame();
        get_result(1, 1'b0);

        // out_ready high ahead of the frame has no effect on accumulation
        out_ready = 1'b1;
        frame_q = '{8'h81, 8'h42, 8'h24};
        send_frame();
        get_result(0, 1'b0);

        // Reset in ACCUM after 0x0F, 0xF0
        drive_word(8'h0F, 1'b0);
        drive_word(8'hF0, 1'b0);
        check("accum_state", {30'd0, u0_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_accum");
        @(negedge clk);
        rst_n = 1'b1;
        frame_q = '{8'hFF};
        send_frame();
        get_result(0, 1'b0);

        // Reset in HOLD discards the pending result
        frame_q = '{8'h33, 8'h11};
        send_frame();
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_hold");
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {29'd0, u0_out_valid, u1_out_valid, u2_out_valid}, 32'd0);

        // Random frames with random consumer stalls
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom_range(0, 255)));
            send_frame();
            get_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("queue_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
